scf_trace_queue: RTL and testbench
==================================

Name: scf_trace_queue

Overview:
- Downstream consumer of the SCF control-flow filter.
- Each cycle it samples the filter's 64-bit output word {pc[31:0], instr[31:0]}, discards all-zero (filtered-out) words, tags survivors with a control-flow kind, and buffers them in a FIFO.
- The FIFO drains to the trace sink over a valid/ready handshake.
- The filter cannot be stalled, so words arriving while the FIFO is full are dropped and counted.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the saturating drop and accept counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_word is meaningful this cycle.
- in_word  in  64  filter output: [63:32] pc, [31:0] instr.
- out_valid  out  1  head entry available.
- out_ready  in  1  sink accepts the head this cycle.
- out_word  out  64  head word.
- out_kind  out  3  head kind tag.
- level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  CNT_W  words lost to a full FIFO; saturates.
- accept_cnt  out  CNT_W  words enqueued; saturates.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_word=0, out_kind=0, level=0, drop_cnt=0, accept_cnt=0; read and write pointers cleared.
  - Reset mid-operation discards all FIFO contents immediately.
- Push request: in_valid=1 and in_word!=0. A zero word is ignored and counts as neither accept nor drop.
- Pop: out_valid && out_ready.
- Kind classification, combinational on in_word[31:0] and stored alongside the word. op=instr[31:26], funct=instr[5:0], rt=instr[20:16]:
  - op 4..7 -> KIND_BRANCH (1)
  - op 2,3 -> KIND_JUMP (2)
  - op 0 and funct 8 or 9 -> KIND_JREG (3)
  - op 1 and rt in {0,1,16,17} -> KIND_REGIMM (4)
  - else -> KIND_OTHER (0)
- FIFO is show-ahead:
  - out_word and out_kind reflect the head entry whenever level>0; both are 0 when empty.
  - out_valid = (level!=0).
- Latency: a word pushed into an empty FIFO at edge N appears at the outputs with out_valid=1 after edge N; minimum 1 cycle input to output.
- No combinational path from in_* to out_*.
- Full (level==DEPTH):
  - Push with no simultaneous pop -> word dropped; drop_cnt += 1, saturating at 2^CNT_W-1.
  - Push with a simultaneous pop -> both happen; level unchanged; no drop.
- Empty: a pop cannot occur (out_valid=0); a push is accepted and level becomes 1.
- Simultaneous push and pop at any level: level unchanged; ordering preserved.
- Pointers wrap modulo DEPTH; level distinguishes full from empty.
- accept_cnt += 1 per enqueued word, saturating.
- out_word and out_kind must hold stable while out_valid=1 and out_ready=0.

Decomposition:
- Package scf_pkg holds:
  - kind typedef (3-bit enum: KIND_OTHER, KIND_BRANCH, KIND_JUMP, KIND_JREG, KIND_REGIMM);
  - opcode and funct constants (OP_SPECIAL=0, OP_REGIMM=1, OP_J=2, OP_JAL=3, OP_BEQ..OP_BGTZ=4..7, FN_JR=8, FN_JALR=9);
  - field position constants PC_LSB=32, OP_LSB=26.
- One sub-module, scf_kind_decode: a pure combinational instr -> kind decoder, reused by the verification scoreboard.
- FIFO storage stays inline.

Test Plan:
- Single branch: in_word=64'h0040_0010_1000_0003 with in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_word equal to the input, out_kind=1; accept_cnt=1; FIFO empty the following cycle.
- Kind coverage with out_ready=1: instr 32'h0800_0004 -> kind 2; 32'h03E0_0008 -> kind 3; 32'h0400_0002 -> kind 4; 32'h8C41_0000 -> kind 0. Words emerge in order.
- Zero filtering: in_valid=1 with in_word=0 for 10 cycles -> level=0, accept_cnt=0, drop_cnt=0, out_valid=0.
- Overflow: out_ready=0, push DEPTH+3=11 distinct nonzero words -> level=8, drop_cnt=3, head=first word. Then drain with out_ready=1 -> exactly words 1..8 returned.
- Full with simultaneous push and pop: FIFO full, one push while out_ready=1 -> level stays 8, drop_cnt unchanged, new word ends up at the tail.
- Async reset mid-stream: assert rst between edges while level=5 -> out_valid, level and counters go to 0 immediately without a clock edge. After release, the first new push appears after one edge.

Source files
------------

// File: rtl/scf_pkg.sv
// Shared types and ISA constants for the SCF trace path: kind tags,
// MIPS opcode/funct values and word field positions.
package scf_pkg;

  typedef enum logic [2:0] {
    KIND_OTHER  = 3'd0,
    KIND_BRANCH = 3'd1,
    KIND_JUMP   = 3'd2,
    KIND_JREG   = 3'd3,
    KIND_REGIMM = 3'd4
  } kind_e;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;

  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_JALR    = 6'd9;

  // REGIMM rt values that are control flow: BLTZ, BGEZ, BLTZAL, BGEZAL.
  localparam logic [4:0] RT_BLTZ    = 5'd0;
  localparam logic [4:0] RT_BGEZ    = 5'd1;
  localparam logic [4:0] RT_BLTZAL  = 5'd16;
  localparam logic [4:0] RT_BGEZAL  = 5'd17;

  localparam int PC_LSB = 32;
  localparam int OP_LSB = 26;

endpackage

// File: rtl/scf_kind_decode.sv
// Pure combinational classifier: 32-bit MIPS instruction -> control-flow kind.
module scf_kind_decode
  import scf_pkg::*;
(
  input  logic [31:0] i_instr,
  output kind_e       o_kind
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rt;

  assign w_op    = i_instr[OP_LSB +: 6];
  assign w_funct = i_instr[5:0];
  assign w_rt    = i_instr[20:16];

  // NOTE: o_kind gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    o_kind = KIND_OTHER;
    if (w_op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}) begin
      o_kind = KIND_BRANCH;
    end else if (w_op inside {OP_J, OP_JAL}) begin
      o_kind = KIND_JUMP;
    end else if (w_op == OP_SPECIAL && (w_funct inside {FN_JR, FN_JALR})) begin
      o_kind = KIND_JREG;
    end else if (w_op == OP_REGIMM &&
                 (w_rt inside {RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL})) begin
      o_kind = KIND_REGIMM;
    end
  end

endmodule

// File: rtl/scf_trace_queue.sv
// Show-ahead trace FIFO behind the SCF filter: drops zero words, tags kinds,
// drops and counts words that arrive while full (the filter cannot stall).
module scf_trace_queue
  import scf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [63:0]              in_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_word,
  output logic [2:0]               out_kind,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         accept_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [63:0]      r_mem_word [DEPTH];
  kind_e            r_mem_kind [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_accept_cnt;

  kind_e w_in_kind;
  logic  w_push_req;
  logic  w_empty;
  logic  w_full;
  logic  w_pop;
  logic  w_push;
  logic  w_drop;

  scf_kind_decode u_kind_decode (
    .i_instr (in_word[31:0]),
    .o_kind  (w_in_kind)
  );

  assign w_push_req = in_valid && (in_word != '0);
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_FULL);
  assign w_pop      = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_drop_cnt   <= '0;
      r_accept_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_drop && r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
      if (w_push && r_accept_cnt != '1) begin
        r_accept_cnt <= r_accept_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; level gates every read, so stale
  // entries are never visible and the array can map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_word[r_wr_ptr] <= in_word;
      r_mem_kind[r_wr_ptr] <= w_in_kind;
    end
  end

  assign out_valid  = !w_empty;
  assign out_word   = w_empty ? 64'd0 : r_mem_word[r_rd_ptr];
  assign out_kind   = w_empty ? 3'd0  : r_mem_kind[r_rd_ptr];
  assign level      = r_level;
  assign drop_cnt   = r_drop_cnt;
  assign accept_cnt = r_accept_cnt;

endmodule

// File: tb/tb_scf_trace_queue.sv
// Scoreboard bench for scf_trace_queue: a reference queue model predicts
// head word/kind, level and counters every cycle.
module tb_scf_trace_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [63:0]      in_word;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_word;
  logic [2:0]       out_kind;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] accept_cnt;

  scf_trace_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_kind   (out_kind),
    .level      (level),
    .drop_cnt   (drop_cnt),
    .accept_cnt (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] word;
    logic [2:0]  kind;
  } sb_t;

  sb_t sb[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  m_drop      = 0;
  int  m_accept    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reading of the kind table, written as a flat opcode case.
  function automatic logic [2:0] ref_kind(input logic [31:0] ins);
    logic [2:0] k;
    k = 3'd0;
    case (ins[31:26])
      6'd4, 6'd5, 6'd6, 6'd7: k = 3'd1;
      6'd2, 6'd3:             k = 3'd2;
      6'd0: if (ins[5:0] == 6'd8 || ins[5:0] == 6'd9) k = 3'd3;
      6'd1: if (ins[20:16] == 5'd0 || ins[20:16] == 5'd1 ||
                ins[20:16] == 5'd16 || ins[20:16] == 5'd17) k = 3'd4;
      default: k = 3'd0;
    endcase
    return k;
  endfunction

  // Called 1 time unit after a rising edge: drive, check outputs, update model, advance.
  task automatic step(input logic v, input logic [63:0] w, input logic rdy);
    bit exp_pop;
    bit exp_full;
    sb_t e;
    in_valid  = v;
    in_word   = w;
    out_ready = rdy;
    #1;
    check("level", 64'(level), 64'(sb.size()));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("accept_cnt", 64'(accept_cnt), 64'(m_accept));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("head_word", out_word, sb[0].word);
      check("head_kind", 64'(out_kind), 64'(sb[0].kind));
    end else begin
      check("empty_word", out_word, 64'd0);
      check("empty_kind", 64'(out_kind), 64'd0);
    end
    exp_pop  = (sb.size() != 0) && rdy;
    exp_full = (sb.size() == DEPTH);
    if (exp_pop) void'(sb.pop_front());
    if (v && w != 64'd0) begin
      if (!exp_full || exp_pop) begin
        e.word = w;
        e.kind = ref_kind(w[31:0]);
        sb.push_back(e);
        if (m_accept < (1 << CNT_W) - 1) m_accept++;
      end else begin
        if (m_drop < (1 << CNT_W) - 1) m_drop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (sb.size() != 0) step(1'b0, 64'd0, 1'b1);
    end
    check("drained_level", 64'(level), 64'd0);
  endtask

  logic [31:0] kind_instr [4];
  logic [2:0]  kind_exp   [4];
  logic [63:0] ovf_words  [11];
  logic [63:0] extra_word;

  initial begin
    kind_instr[0] = 32'h0800_0004; kind_exp[0] = 3'd2;
    kind_instr[1] = 32'h03E0_0008; kind_exp[1] = 3'd3;
    kind_instr[2] = 32'h0400_0002; kind_exp[2] = 3'd4;
    kind_instr[3] = 32'h8C41_0000; kind_exp[3] = 3'd0;
    for (int i = 0; i < 11; i++) begin
      ovf_words[i] = {32'h0040_1000 + 32'(i * 4),
                      (i % 2 == 0) ? 32'h1000_0000 + 32'(i) : 32'h8C41_0000 + 32'(i)};
    end

    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_word", out_word, 64'd0);
    check("rst_kind", 64'(out_kind), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_accept", 64'(accept_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero words are neither accepted nor dropped.
    for (int i = 0; i < 10; i++) step(1'b1, 64'd0, 1'b1);
    check("zero_level", 64'(level), 64'd0);
    check("zero_accept", 64'(accept_cnt), 64'd0);
    check("zero_drop", 64'(drop_cnt), 64'd0);
    check("zero_valid", 64'(out_valid), 64'd0);

    // Single branch, one-cycle latency.
    step(1'b1, 64'h0040_0010_1000_0003, 1'b1);
    check("br_valid", 64'(out_valid), 64'd1);
    check("br_word", out_word, 64'h0040_0010_1000_0003);
    check("br_kind", 64'(out_kind), 64'd1);
    check("br_accept", 64'(accept_cnt), 64'd1);
    step(1'b0, 64'd0, 1'b1);
    check("br_empty", 64'(out_valid), 64'd0);

    // Kind coverage, streamed back to back with the sink always ready.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {32'h0040_2000 + 32'(i * 4), kind_instr[i]}, 1'b1);
      check("kind_tbl", 64'(out_kind), 64'(kind_exp[i]));
    end
    drain();

    // Overflow with a stalled sink, then drain in order.
    for (int i = 0; i < 11; i++) step(1'b1, ovf_words[i], 1'b0);
    check("ovf_level", 64'(level), 64'd8);
    check("ovf_drop", 64'(drop_cnt), 64'd3);
    check("ovf_head", out_word, ovf_words[0]);
    drain();

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < DEPTH; i++) step(1'b1, ovf_words[i], 1'b0);
    extra_word = 64'h0040_3000_0800_0123;
    step(1'b1, extra_word, 1'b1);
    check("pp_level", 64'(level), 64'd8);
    check("pp_drop", 64'(drop_cnt), 64'd3);
    check("pp_tail", sb[DEPTH-1].word, extra_word);
    drain();

    // Asynchronous reset with five entries queued.
    for (int i = 0; i < 5; i++) step(1'b1, ovf_words[i], 1'b0);
    check("ar_pre_level", 64'(level), 64'd5);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_level", 64'(level), 64'd0);
    check("ar_drop", 64'(drop_cnt), 64'd0);
    check("ar_accept", 64'(accept_cnt), 64'd0);
    check("ar_word", out_word, 64'd0);
    sb.delete();
    m_drop   = 0;
    m_accept = 0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 64'h0040_4000_0400_0011, 1'b0);
    check("ar_post_valid", 64'(out_valid), 64'd1);
    check("ar_post_word", out_word, 64'h0040_4000_0400_0011);
    check("ar_post_kind", 64'(out_kind), 64'd4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
